btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 82 ++++++++
 tb/tb_btn_debounce.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Per-channel button debouncer: two-flop synchronizer, stable-state counter filter,
// press/release pulses, sticky press flags and a combined interrupt.
module btn_debounce #(
  parameter int NUM_BTN         = 8,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic               mask_i,
  input  logic               evt_ack_i,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] btn_raw_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] pend_o,
  output logic               irq_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]                r_sync1;
  logic [NUM_BTN-1:0]                r_sync2;
  logic [NUM_BTN-1:0]                r_stable;
  logic [NUM_BTN-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [NUM_BTN-1:0]                r_press;
  logic [NUM_BTN-1:0]                r_release;
  logic [NUM_BTN-1:0]                r_pend;

  logic [NUM_BTN-1:0] w_diff;
  logic [NUM_BTN-1:0] w_accept;
  logic [NUM_BTN-1:0] w_evt_en;

  always_comb begin
    w_diff   = r_sync2 ^ r_stable;
    w_evt_en = {NUM_BTN{~mask_i}};
    w_accept = '0;
    for (int n = 0; n < NUM_BTN; n++) begin
      w_accept[n] = w_diff[n] && (r_cnt[n] == LAST_CNT);
    end
  end

  // The counter only runs while the synchronized level disagrees with the stable
  // state, so any bounce back to the stable level discards the partial count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_stable  <= '1;
      r_cnt     <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_pend    <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      for (int n = 0; n < NUM_BTN; n++) begin
        if (!w_diff[n]) begin
          r_cnt[n] <= '0;
        end else if (w_accept[n]) begin
          r_cnt[n]    <= '0;
          r_stable[n] <= r_sync2[n];
        end else begin
          r_cnt[n] <= r_cnt[n] + CNT_WIDTH'(1);
        end
      end
      r_press   <= w_accept & ~r_sync2 & w_evt_en;
      r_release <= w_accept &  r_sync2 & w_evt_en;
      // A press arriving together with an acknowledge keeps its flag set.
      r_pend    <= (evt_ack_i ? '0 : r_pend) | (r_press & w_evt_en);
    end
  end

  assign btn_raw_o = r_stable;
  assign btn_o     = mask_i ? '1 : r_stable;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign pend_o    = r_pend;
  assign irq_o     = |r_pend;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus pushes timed expectations, a
// negedge monitor pops and compares them, and checks pulse outputs every cycle.
module tb_btn_debounce;

  localparam int NB = 8;
  localparam int DC = 16;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_RAW   = 2;
  localparam int K_BTN   = 3;
  localparam int K_PEND  = 4;
  localparam int K_IRQ   = 5;

  typedef struct {
    int           cyc;
    int           kind;
    logic [NB-1:0] val;
    string        tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn;
  logic          mask;
  logic          ack;
  logic [NB-1:0] btnOut, rawOut, pressOut, releaseOut, pendOut;
  logic          irqOut;

  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   monEn = 1'b0;
  exp_t sb[$];
  logic [NB-1:0] expPress, expRel;

  btn_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_i    (btn),
    .mask_i   (mask),
    .evt_ack_i(ack),
    .btn_o    (btnOut),
    .btn_raw_o(rawOut),
    .press_o  (pressOut),
    .release_o(releaseOut),
    .pend_o   (pendOut),
    .irq_o    (irqOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  task automatic checkOutput(input string tag, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @cycle %0d: got %h expected %h", tag, cycle, act, exp);
    end
  endtask

  task automatic expectAt(input int dly, input int kind, input logic [NB-1:0] val, input string tag);
    exp_t e;
    e.cyc  = cycle + dly;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] b, input logic m, input logic a, input logic r);
    btn  = b;
    mask = m;
    ack  = a;
    rst  = r;
  endtask

  // Pulse outputs must be zero on every cycle that has no scheduled event.
  always @(negedge clk) begin
    if (monEn) begin
      expPress = '0;
      expRel   = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cycle) begin
          case (sb[i].kind)
            K_PRESS: expPress = expPress | sb[i].val;
            K_REL:   expRel   = expRel   | sb[i].val;
            K_RAW:   checkOutput(sb[i].tag, rawOut,  sb[i].val);
            K_BTN:   checkOutput(sb[i].tag, btnOut,  sb[i].val);
            K_PEND:  checkOutput(sb[i].tag, pendOut, sb[i].val);
            default: checkOutput(sb[i].tag, {{(NB-1){1'b0}}, irqOut}, sb[i].val);
          endcase
          sb.delete(i);
        end
      end
      checkOutput("press", pressOut, expPress);
      checkOutput("release", releaseOut, expRel);
    end
  end

  initial begin
    int c;
    applyStimulus('1, 1'b0, 1'b0, 1'b1);
    step(1);
    monEn = 1'b1;
    expectAt(1, K_RAW,  8'hFF, "rst_raw");
    expectAt(1, K_BTN,  8'hFF, "rst_btn");
    expectAt(1, K_PEND, 8'h00, "rst_pend");
    expectAt(1, K_IRQ,  8'h00, "rst_irq");
    step(3);
    applyStimulus('1, 1'b0, 1'b0, 1'b0);
    step(3);

    // Clean press on channel 0
    c = cycle;
    applyStimulus(8'hFE, 1'b0, 1'b0, 1'b0);
    expectAt(17, K_RAW,   8'hFF, "t1_raw_early");
    expectAt(18, K_RAW,   8'hFE, "t1_raw");
    expectAt(18, K_BTN,   8'hFE, "t1_btn");
    expectAt(18, K_PRESS, 8'h01, "t1_press");
    expectAt(18, K_PEND,  8'h00, "t1_pend_early");
    expectAt(19, K_PEND,  8'h01, "t1_pend");
    expectAt(19, K_IRQ,   8'h01, "t1_irq");
    step(22);

    // Bounces on channel 2 shorter than the debounce window
    applyStimulus(8'hFA, 1'b0, 1'b0, 1'b0);
    step(10);
    applyStimulus(8'hFE, 1'b0, 1'b0, 1'b0);
    step(2);
    applyStimulus(8'hFA, 1'b0, 1'b0, 1'b0);
    step(DC - 1);
    applyStimulus(8'hFE, 1'b0, 1'b0, 1'b0);
    step(20);
    expectAt(1, K_RAW,  8'hFE, "t2_raw");
    expectAt(1, K_PEND, 8'h01, "t2_pend");
    step(2);

    // Channels 5,6,7 together; channel 5 held exactly DC cycles then released
    c = cycle;
    applyStimulus(8'h1E, 1'b0, 1'b0, 1'b0);
    expectAt(18, K_PRESS, 8'hE0, "t3_press");
    expectAt(18, K_RAW,   8'h1E, "t3_raw");
    expectAt(19, K_PEND,  8'hE1, "t3_pend");
    step(DC);
    applyStimulus(8'h3E, 1'b0, 1'b0, 1'b0);
    expectAt(17, K_RAW,   8'h1E, "t3_raw_hold");
    expectAt(18, K_REL,   8'h20, "t3_release");
    expectAt(18, K_RAW,   8'h3E, "t3_raw_rel");
    step(22);

    // Release channels 0,6,7 simultaneously
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    expectAt(17, K_RAW,  8'h3E, "t3b_raw_early");
    expectAt(18, K_REL,  8'hC1, "t3b_release");
    expectAt(18, K_RAW,  8'hFF, "t3b_raw");
    expectAt(19, K_PEND, 8'hE1, "t3b_pend");
    step(22);

    // Acknowledge in the same cycle as the channel 3 press
    applyStimulus(8'hF7, 1'b0, 1'b0, 1'b0);
    expectAt(18, K_PRESS, 8'h08, "t4_press");
    expectAt(18, K_PEND,  8'hE1, "t4_pend_before");
    expectAt(19, K_PEND,  8'h08, "t4_pend_set_wins");
    expectAt(19, K_IRQ,   8'h01, "t4_irq");
    step(18);
    applyStimulus(8'hF7, 1'b0, 1'b1, 1'b0);
    step(1);
    applyStimulus(8'hF7, 1'b0, 1'b0, 1'b0);
    step(3);
    applyStimulus(8'hF7, 1'b0, 1'b1, 1'b0);
    expectAt(1, K_PEND, 8'h00, "t4_ack_clear");
    expectAt(1, K_IRQ,  8'h00, "t4_irq_clear");
    step(1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    expectAt(18, K_REL, 8'h08, "t4_release");
    step(22);

    // Masked press on channel 1
    applyStimulus(8'hFD, 1'b1, 1'b0, 1'b0);
    expectAt(1,  K_BTN,  8'hFF, "t5_btn_masked");
    expectAt(18, K_RAW,  8'hFD, "t5_raw");
    expectAt(18, K_BTN,  8'hFF, "t5_btn_masked2");
    expectAt(19, K_PEND, 8'h00, "t5_pend");
    expectAt(19, K_IRQ,  8'h00, "t5_irq");
    step(22);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    expectAt(1,  K_BTN, 8'hFD, "t5_btn_unmasked");
    expectAt(18, K_REL, 8'h02, "t5_release");
    expectAt(18, K_BTN, 8'hFF, "t5_btn_rel");
    step(22);

    // Reset in the middle of a channel 4 count, button kept held
    applyStimulus(8'hEF, 1'b0, 1'b0, 1'b0);
    step(11);
    applyStimulus(8'hEF, 1'b0, 1'b0, 1'b1);
    expectAt(1, K_RAW,  8'hFF, "t6_rst_raw");
    expectAt(1, K_BTN,  8'hFF, "t6_rst_btn");
    expectAt(1, K_PEND, 8'h00, "t6_rst_pend");
    expectAt(1, K_IRQ,  8'h00, "t6_rst_irq");
    step(3);
    applyStimulus(8'hEF, 1'b0, 1'b0, 1'b0);
    expectAt(17, K_RAW,   8'hFF, "t6_raw_early");
    expectAt(18, K_RAW,   8'hEF, "t6_raw");
    expectAt(18, K_PRESS, 8'h10, "t6_press");
    expectAt(19, K_PEND,  8'h10, "t6_pend");
    step(24);

    monEn = 1'b0;
    checkOutput("sb_drain", NB'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
